// File: rtl/spi_seq_pkg.sv
// Shared constants and types for the SPI pixel sequencer: word width, FSM states,
// transmit status bit positions and default window/watchdog sizes.
package spi_seq_pkg;

  localparam int MAX_PIXEL_BITS         = 24;
  localparam int DEFAULT_WINDOW_PIXELS  = 9;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Bit positions inside the status byte (data_tx_o[23:16])
  localparam int STAT_READY   = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPUTE = 2'd2,
    RESULT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer into the clk_i domain, async active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_pixel_sequencer.sv
// Sequencer between the SPI slave core and the Sobel datapath (windows of pixels in,
// filter result out). Define SPI_SEQ_TIMEOUT_EN to enable the COMPUTE watchdog.
module spi_pixel_sequencer
  import spi_seq_pkg::*;
#(
  parameter int WINDOW_PIXELS = DEFAULT_WINDOW_PIXELS
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      cs_i,
  input  logic                      rxtx_done_i,
  input  logic [MAX_PIXEL_BITS-1:0] data_rx_i,
  output logic [MAX_PIXEL_BITS-1:0] data_tx_o,
  output logic [MAX_PIXEL_BITS-1:0] pix_o,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic                      pix_last_o,
  input  logic [7:0]                result_i,
  input  logic                      result_valid_i,
  output logic                      overrun_o,
  output seq_state_t                state_o
);

  localparam int            CW       = $clog2(WINDOW_PIXELS);
  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW_PIXELS - 1);

  logic cs_sync;
  logic done_sync;

  sync_2ff u_sync_cs (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d_i      (cs_i),
    .q_o      (cs_sync)
  );

  sync_2ff u_sync_done (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d_i      (rxtx_done_i),
    .q_o      (done_sync)
  );

  seq_state_t                state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [MAX_PIXEL_BITS-1:0] pix_q, pix_d;
  logic                      pix_valid_q, pix_valid_d;
  logic [MAX_PIXEL_BITS-1:0] data_tx_q, data_tx_d;
  logic                      overrun_q, overrun_d;
  logic                      done_prev_q;

  logic word_event;
  logic handshake;
  logic last_beat;
  logic [7:0] status;

  assign word_event = done_sync & ~done_prev_q;
  assign handshake  = pix_valid_q & pix_ready_i;
  assign last_beat  = pix_valid_q & (count_q == LAST_IDX);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pix_d       = pix_q;
    pix_valid_d = pix_valid_q;
    data_tx_d   = data_tx_q;
    overrun_d   = overrun_q;
    status      = 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    if (handshake) pix_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!cs_sync) begin
          state_d   = COLLECT;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end
      COLLECT: begin
        if (handshake) begin
          if (last_beat) begin
            state_d = COMPUTE;
            count_d = '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        // A word arriving while the previous pixel is still pending, or as the
        // window closes, has nowhere to go.
        if (word_event) begin
          if ((pix_valid_q && !pix_ready_i) || (handshake && last_beat)) begin
            overrun_d = 1'b1;
          end else begin
            pix_d       = data_rx_i;
            pix_valid_d = 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (word_event) overrun_d = 1'b1;
        status[STAT_READY]   = 1'b1;
        status[STAT_OVERRUN] = overrun_d;
        if (result_valid_i) begin
          data_tx_d = {status, 8'h00, result_i};
          state_d   = RESULT;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          data_tx_d = {8'h04, 8'h00, 8'h00};
          state_d   = RESULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESULT: begin
        // The read-out dummy word is consumed here and never forwarded.
        if (word_event) begin
          data_tx_d[16 + STAT_READY] = 1'b0;
          state_d                    = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cs_sync) begin
      state_d     = IDLE;
      count_d     = '0;
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      data_tx_q   <= '0;
      overrun_q   <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      data_tx_q   <= data_tx_d;
      overrun_q   <= overrun_d;
      done_prev_q <= done_sync;
    end
  end

  assign data_tx_o   = data_tx_q;
  assign pix_o       = pix_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_last_o  = last_beat;
  assign overrun_o   = overrun_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_spi_pixel_sequencer.sv
// Directed bench for spi_pixel_sequencer: windows, result staging, overrun, cs abort,
// watchdog (SPI_SEQ_TIMEOUT_EN) and mid-window reset.
module tb_spi_pixel_sequencer;
  import spi_seq_pkg::*;

  localparam int W = MAX_PIXEL_BITS;

  logic          clk_i = 1'b0;
  logic          nreset_i;
  logic          cs_i;
  logic          rxtx_done_i;
  logic [W-1:0]  data_rx_i;
  logic [W-1:0]  data_tx_o;
  logic [W-1:0]  pix_o;
  logic          pix_valid_o;
  logic          pix_ready_i;
  logic          pix_last_o;
  logic [7:0]    result_i;
  logic          result_valid_i;
  logic          overrun_o;
  seq_state_t    state_o;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [W-1:0] got_q[$];
  logic         got_last_q[$];

  spi_pixel_sequencer dut (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .cs_i           (cs_i),
    .rxtx_done_i    (rxtx_done_i),
    .data_rx_i      (data_rx_i),
    .data_tx_o      (data_tx_o),
    .pix_o          (pix_o),
    .pix_valid_o    (pix_valid_o),
    .pix_ready_i    (pix_ready_i),
    .pix_last_o     (pix_last_o),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .overrun_o      (overrun_o),
    .state_o        (state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // Inputs change on negedge, so these pre-edge values are the ones the DUT samples.
  always @(posedge clk_i) begin
    if (nreset_i && pix_valid_o && pix_ready_i) begin
      got_q.push_back(pix_o);
      got_last_q.push_back(pix_last_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one SPI word, rxtx_done high 3 cycles then idle 5 cycles
  task automatic send_word(input logic [W-1:0] w, input bit chk_latency);
    data_rx_i   = w;
    rxtx_done_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    if (chk_latency) check("latency_lo", 32'(pix_valid_o), 32'd0);
    @(negedge clk_i);
    if (chk_latency) check("latency_hi", 32'(pix_valid_o), 32'd1);
    rxtx_done_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic expect_window(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(first + W'(i));
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  // scoreboard: compare forwarded pixels with the expected queue, then drain both
  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check({tag, "_pix"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_last"}, 32'(got_last_q[i]), 32'(exp_last_q[i]));
      end
    end
    exp_q.delete(); exp_last_q.delete(); got_q.delete(); got_last_q.delete();
  endtask

  task automatic pulse_result(input logic [7:0] r);
    result_i       = r;
    result_valid_i = 1'b1;
    @(negedge clk_i);
    result_valid_i = 1'b0;
  endtask

  initial begin
    nreset_i = 1'b0; cs_i = 1'b0; rxtx_done_i = 1'b0; data_rx_i = '0;
    pix_ready_i = 1'b1; result_i = 8'h00; result_valid_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_data_tx", 32'(data_tx_o), 32'h0);
    check("rst_pix", 32'(pix_o), 32'h0);
    check("rst_pix_valid", 32'(pix_valid_o), 32'd0);
    check("rst_pix_last", 32'(pix_last_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));

    nreset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("cs_low_collect", 32'(state_o), 32'(COLLECT));

    // full window 1..9 with ready tied high
    send_word(24'h000001, 1'b1);
    for (int i = 2; i <= 9; i++) send_word(W'(i), 1'b0);
    expect_window(24'h000001, 9);
    check_stream("win1");
    check("win1_state", 32'(state_o), 32'(COMPUTE));

    pulse_result(8'h5A);
    check("res1_tx", 32'(data_tx_o), 32'h01005A);
    check("res1_state", 32'(state_o), 32'(RESULT));
    send_word(24'hFFFFFF, 1'b0);
    check("dummy1_tx", 32'(data_tx_o), 32'h00005A);
    check("dummy1_state", 32'(state_o), 32'(COLLECT));
    check("dummy1_not_fwd", 32'(got_q.size()), 32'd0);

    // overrun: first word held, second dropped
    pix_ready_i = 1'b0;
    send_word(24'h0000AA, 1'b1);
    send_word(24'h0000BB, 1'b0);
    check("ovr_held_valid", 32'(pix_valid_o), 32'd1);
    check("ovr_held_pix", 32'(pix_o), 32'h0000AA);
    check("ovr_flag", 32'(overrun_o), 32'd1);
    pix_ready_i = 1'b1;
    @(negedge clk_i);
    check("ovr_released", 32'(pix_valid_o), 32'd0);
    for (int i = 0; i < 8; i++) send_word(24'h000010 + W'(i), 1'b0);
    exp_q.push_back(24'h0000AA); exp_last_q.push_back(1'b0);
    expect_window(24'h000010, 8);
    exp_last_q[0] = 1'b0;
    check_stream("win2");
    check("win2_state", 32'(state_o), 32'(COMPUTE));
    pulse_result(8'h33);
    check("res2_tx", 32'(data_tx_o), 32'h030033);
    send_word(24'h000000, 1'b0);
    check("dummy2_tx", 32'(data_tx_o), 32'h020033);

    // result strobe outside COMPUTE is ignored
    pulse_result(8'h77);
    check("stray_res_tx", 32'(data_tx_o), 32'h020033);
    check("stray_res_state", 32'(state_o), 32'(COLLECT));

    // cs abort after 4 pixels
    for (int i = 0; i < 4; i++) send_word(24'h000020 + W'(i), 1'b0);
    got_q.delete(); got_last_q.delete();
    cs_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("abort_state", 32'(state_o), 32'(IDLE));
    check("abort_valid", 32'(pix_valid_o), 32'd0);
    check("abort_ovr_kept", 32'(overrun_o), 32'd1);
    check("abort_tx_kept", 32'(data_tx_o), 32'h020033);
    cs_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("recs_state", 32'(state_o), 32'(COLLECT));
    check("recs_ovr_clr", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 9; i++) send_word(24'h000030 + W'(i), 1'b0);
    expect_window(24'h000030, 9);
    check_stream("win3");
    check("win3_state", 32'(state_o), 32'(COMPUTE));

`ifdef SPI_SEQ_TIMEOUT_EN
    for (int i = 0; i < 400 && state_o != RESULT; i++) @(negedge clk_i);
    check("tmo_state", 32'(state_o), 32'(RESULT));
    check("tmo_tx", 32'(data_tx_o), 32'h040000);
`else
    repeat (300) @(negedge clk_i);
    check("no_tmo_state", 32'(state_o), 32'(COMPUTE));
    check("no_tmo_tx", 32'(data_tx_o), 32'h020033);
`endif

    // reset in the middle of a window
    cs_i = 1'b1;
    repeat (4) @(negedge clk_i);
    cs_i = 1'b0;
    repeat (4) @(negedge clk_i);
    for (int i = 0; i < 3; i++) send_word(24'h000040 + W'(i), 1'b0);
    pix_ready_i = 1'b0;
    send_word(24'h000043, 1'b0);
    nreset_i = 1'b0;
    #1;
    check("mrst_state", 32'(state_o), 32'(IDLE));
    check("mrst_valid", 32'(pix_valid_o), 32'd0);
    check("mrst_pix", 32'(pix_o), 32'h0);
    check("mrst_tx", 32'(data_tx_o), 32'h0);
    check("mrst_ovr", 32'(overrun_o), 32'd0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    pix_ready_i = 1'b1;
    got_q.delete(); got_last_q.delete();
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 9; i++) send_word(24'h000050 + W'(i), 1'b0);
    expect_window(24'h000050, 9);
    check_stream("win4");
    check("win4_state", 32'(state_o), 32'(COMPUTE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
